// File: rtl/ysyx_23060184_lsu_pkg.sv
// Shared LSU definitions: FSM encodings, strobe constants, size codes.
// Includes the misalignment helper used when YSYX_23060184_LSU_MISALIGN_CHECK_EN is set.
package ysyx_23060184_lsu_pkg;

  localparam int WMASK_LENGTH   = 2;
  localparam int ROPCODE_LENGTH = 3;

  localparam logic [WMASK_LENGTH-1:0] WRITE_BYTE = 2'd1;
  localparam logic [WMASK_LENGTH-1:0] WRITE_HALF = 2'd2;
  localparam logic [WMASK_LENGTH-1:0] WRITE_WORD = 2'd3;

  localparam logic [ROPCODE_LENGTH-1:0] READ_BYTE  = 3'd1;
  localparam logic [ROPCODE_LENGTH-1:0] READ_BYTEU = 3'd2;
  localparam logic [ROPCODE_LENGTH-1:0] READ_HALF  = 3'd3;
  localparam logic [ROPCODE_LENGTH-1:0] READ_HALFU = 3'd4;
  localparam logic [ROPCODE_LENGTH-1:0] READ_WORD  = 3'd5;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;
  localparam logic [3:0] WSTRB_BYTE = 4'b0001;
  localparam logic [3:0] WSTRB_HALF = 4'b0011;
  localparam logic [3:0] WSTRB_WORD = 4'b1111;

  typedef enum logic [1:0] {
    LSU_ST_IDLE = 2'd0,
    LSU_ST_REQ  = 2'd1,
    LSU_ST_WAIT = 2'd2,
    LSU_ST_DONE = 2'd3
  } lsu_state_e;

  // Unknown size codes count as word, so they need full alignment.
  function automatic logic misaligned(
    input logic                      ld,
    input logic [WMASK_LENGTH-1:0]   wm,
    input logic [ROPCODE_LENGTH-1:0] rop,
    input logic [1:0]                a
  );
    logic is_b;
    logic is_h;
    is_b = ld ? (rop == READ_BYTE || rop == READ_BYTEU)
              : (wm == WRITE_BYTE);
    is_h = ld ? (rop == READ_HALF || rop == READ_HALFU)
              : (wm == WRITE_HALF);
    if (is_b)      return 1'b0;
    else if (is_h) return a[0];
    else           return |a;
  endfunction

endpackage

// File: rtl/ysyx_23060184_lsu_align.sv
// Combinational lane steering: store data/strobes and load shift/extend.
// Unknown size codes fall back to full-word behaviour.
import ysyx_23060184_lsu_pkg::*;

module ysyx_23060184_lsu_align (
  input  logic [1:0]                a,
  input  logic [WMASK_LENGTH-1:0]   wmask,
  input  logic [ROPCODE_LENGTH-1:0] rop,
  input  logic [31:0]               wdata,
  input  logic [31:0]               rdata,
  output logic [31:0]               st_data,
  output logic [3:0]                st_strb,
  output logic [31:0]               ld_data
);

  logic [15:0] sh;

  always_comb begin
    st_data = wdata;
    st_strb = WSTRB_WORD;
    unique case (1'b1)
      (wmask == WRITE_BYTE): begin
        st_data = {4{wdata[7:0]}};
        st_strb = WSTRB_BYTE << a;
      end
      (wmask == WRITE_HALF): begin
        st_data = {2{wdata[15:0]}};
        st_strb = WSTRB_HALF << {a[1], 1'b0};
      end
      default: begin
        st_data = wdata;
        st_strb = WSTRB_WORD;
      end
    endcase
  end

  always_comb begin
    sh      = 16'(rdata >> {a, 3'b000});
    ld_data = rdata;
    unique case (1'b1)
      (rop == READ_BYTE):  ld_data = {{24{sh[7]}}, sh[7:0]};
      (rop == READ_BYTEU): ld_data = {24'd0, sh[7:0]};
      (rop == READ_HALF):  ld_data = {{16{sh[15]}}, sh};
      (rop == READ_HALFU): ld_data = {16'd0, sh};
      default:             ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_23060184_lsu.sv
// Load/store unit: one memory transaction per instruction, valid/ready on all sides.
// Define YSYX_23060184_LSU_MISALIGN_CHECK_EN to fault misaligned half/word accesses.
import ysyx_23060184_lsu_pkg::*;

module ysyx_23060184_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [DATA_W-1:0]         in_wdata,
  input  logic [DATA_W-1:0]         in_alu,
  input  logic                      MemRead,
  input  logic                      MemWrite,
  input  logic [WMASK_LENGTH-1:0]   Wmask,
  input  logic [ROPCODE_LENGTH-1:0] Ropcode,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [3:0]                mem_wstrb,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_fault
);

  lsu_state_e state_q, state_d;

  logic [ADDR_W-1:0]         addr_q;
  logic [DATA_W-1:0]         wdata_q;
  logic [WMASK_LENGTH-1:0]   wmask_q;
  logic [ROPCODE_LENGTH-1:0] rop_q;
  logic                      ld_q;
  logic [DATA_W-1:0]         data_q;
  logic                      mem_op;
  logic                      bad;
  logic                      accept;
  logic [31:0]               st_data;
  logic [3:0]                st_strb;
  logic [31:0]               ld_data;

  assign mem_op = MemRead | MemWrite;
  assign accept = (state_q == LSU_ST_IDLE) & in_valid;

  always_comb begin
`ifdef YSYX_23060184_LSU_MISALIGN_CHECK_EN
    bad = mem_op & misaligned(MemRead, Wmask, Ropcode, in_addr[1:0]);
`else
    bad = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= LSU_ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LSU_ST_IDLE:
        if (in_valid)
          state_d = (mem_op && !bad) ? LSU_ST_REQ : LSU_ST_DONE;
      LSU_ST_REQ:  if (mem_req_ready) state_d = LSU_ST_WAIT;
      LSU_ST_WAIT: if (mem_rsp_valid) state_d = LSU_ST_DONE;
      LSU_ST_DONE: if (out_ready)     state_d = LSU_ST_IDLE;
      default:                        state_d = LSU_ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (state_q == LSU_ST_IDLE);
    mem_req_valid = (state_q == LSU_ST_REQ);
    mem_we        = mem_req_valid & ~ld_q;
    mem_wstrb     = mem_we ? st_strb : WSTRB_NONE;
    mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
    mem_wdata     = st_data;
    out_valid     = (state_q == LSU_ST_DONE);
    out_data      = data_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rop_q   <= '0;
      ld_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        wmask_q <= Wmask;
        rop_q   <= Ropcode;
        ld_q    <= MemRead;
        if (bad)          data_q <= '0;
        else if (!mem_op) data_q <= in_alu;
      end
      if (state_q == LSU_ST_WAIT && mem_rsp_valid)
        data_q <= ld_q ? ld_data : '0;
    end
  end

`ifdef YSYX_23060184_LSU_MISALIGN_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       fault_q <= 1'b0;
    else if (accept) fault_q <= bad;
  end
  assign out_fault = fault_q;
`else
  assign out_fault = 1'b0;
`endif

  ysyx_23060184_lsu_align u_align (
    .a       (addr_q[1:0]),
    .wmask   (wmask_q),
    .rop     (rop_q),
    .wdata   (wdata_q),
    .rdata   (mem_rdata),
    .st_data (st_data),
    .st_strb (st_strb),
    .ld_data (ld_data)
  );

endmodule

// File: tb/tb_ysyx_23060184_lsu.sv
// Directed bench for ysyx_23060184_lsu with immediate-assertion checks.
// Misalignment expectations follow YSYX_23060184_LSU_MISALIGN_CHECK_EN.
import ysyx_23060184_lsu_pkg::*;

module tb_ysyx_23060184_lsu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [31:0] in_alu = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [1:0]  Wmask = '0;
  logic [2:0]  Ropcode = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_fault;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_23060184_lsu dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_alu        (in_alu),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .Wmask         (Wmask),
    .Ropcode       (Ropcode),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_fault     (out_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr,
                       input logic [1:0] wm, input logic [2:0] rop,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] alu);
    MemRead  = rd;
    MemWrite = wr;
    Wmask    = wm;
    Ropcode  = rop;
    in_addr  = a;
    in_wdata = d;
    in_alu   = alu;
    in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  // From REQ (ready=1): handshake, one-cycle response, land in DONE.
  task automatic finish_mem();
    tick();
    mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  task automatic ld(input logic [2:0] rop, input logic [31:0] a,
                    input logic [31:0] rd, input logic [31:0] exp,
                    input string tag);
    issue(1'b1, 1'b0, 2'd0, rop, a, 32'd0, 32'd0);
    chk("ld_req_valid", 32'(mem_req_valid), 1);
    chk("ld_we", 32'(mem_we), 0);
    mem_rdata = rd;
    finish_mem();
    chk(tag, out_data, exp);
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    #3;
    chk("rst_req_valid", 32'(mem_req_valid), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_fault", 32'(out_fault), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_wstrb", 32'(mem_wstrb), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rstn = 1'b1;
    tick();

    // sw: request at N+1, out_valid at N+3
    issue(1'b0, 1'b1, WRITE_WORD, 3'd0, 32'h100, 32'h11223344, 32'h55);
    chk("sw_req_valid", 32'(mem_req_valid), 1);
    chk("sw_we", 32'(mem_we), 1);
    chk("sw_wstrb", 32'(mem_wstrb), 32'hF);
    chk("sw_wdata", mem_wdata, 32'h11223344);
    chk("sw_addr", mem_addr, 32'h100);
    chk("sw_no_out", 32'(out_valid), 0);
    tick();
    chk("sw_wait_req", 32'(mem_req_valid), 0);
    chk("sw_wait_out", 32'(out_valid), 0);
    mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    chk("sw_out_valid", 32'(out_valid), 1);
    chk("sw_out_data", out_data, 0);
    tick();
    chk("sw_idle_out", 32'(out_valid), 0);

    // sb to top lane
    issue(1'b0, 1'b1, WRITE_BYTE, 3'd0, 32'h103, 32'h000000AB, 32'h0);
    chk("sb_wstrb", 32'(mem_wstrb), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    chk("sb_addr", mem_addr, 32'h100);
    finish_mem();
    chk("sb_out_data", out_data, 0);
    tick();

    ld(READ_BYTE,  32'h102, 32'h0080FF00, 32'hFFFFFF80, "lb");
    ld(READ_BYTEU, 32'h102, 32'h0080FF00, 32'h00000080, "lbu");
    ld(READ_HALFU, 32'h102, 32'h0080FF00, 32'h00000080, "lhu");
    ld(READ_HALF,  32'h100, 32'h0080FF00, 32'hFFFFFF00, "lh");
    ld(READ_WORD,  32'h104, 32'hDEADBEEF, 32'hDEADBEEF, "lw");
    ld(3'd7,       32'h108, 32'hCAFEF00D, 32'hCAFEF00D, "lunk");

    // MemRead and MemWrite together: load
    issue(1'b1, 1'b1, WRITE_WORD, READ_WORD, 32'h10C, 32'h1, 32'h2);
    chk("rw_we", 32'(mem_we), 0);
    mem_rdata = 32'h12345678;
    finish_mem();
    chk("rw_out_data", out_data, 32'h12345678);
    tick();

    // stalls on both sides with sh at a=0x102
    mem_req_ready = 1'b0;
    issue(1'b0, 1'b1, WRITE_HALF, 3'd0, 32'h102, 32'h0000BEEF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("st_req_valid", 32'(mem_req_valid), 1);
      chk("st_wstrb", 32'(mem_wstrb), 32'hC);
      chk("st_wdata", mem_wdata, 32'hBEEFBEEF);
      chk("st_addr", mem_addr, 32'h100);
      chk("st_in_ready", 32'(in_ready), 0);
      tick();
    end
    mem_req_ready = 1'b1;
    chk("st_req_hold", 32'(mem_req_valid), 1);
    tick();
    chk("st_single_req", 32'(mem_req_valid), 0);
    chk("st_wait_in_ready", 32'(in_ready), 0);
    out_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("st_out_hold", 32'(out_valid), 1);
      chk("st_out_data", out_data, 0);
      chk("st_done_in_ready", 32'(in_ready), 0);
      chk("st_done_no_req", 32'(mem_req_valid), 0);
      tick();
    end
    // upstream already valid in DONE->IDLE cycle: not accepted there
    out_ready = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    in_alu = 32'h77;
    in_valid = 1'b1;
    tick();
    chk("pt_not_early", 32'(out_valid), 0);
    chk("pt_idle_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("pt_out_valid", 32'(out_valid), 1);
    chk("pt_out_data", out_data, 32'h77);
    chk("pt_no_req", 32'(mem_req_valid), 0);
    tick();

    // reset in WAIT, then a stray response
    issue(1'b1, 1'b0, 2'd0, READ_WORD, 32'h200, 32'h0, 32'h0);
    tick();
    #1;
    rstn = 1'b0;
    #1;
    chk("rw_rst_req", 32'(mem_req_valid), 0);
    chk("rw_rst_out", 32'(out_valid), 0);
    chk("rw_rst_data", out_data, 0);
    chk("rw_rst_ready", 32'(in_ready), 1);
    chk("rw_rst_wstrb", 32'(mem_wstrb), 0);
    rstn = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'hA5A5A5A5;
    tick();
    mem_rsp_valid = 1'b0;
    chk("stray_out", 32'(out_valid), 0);
    chk("stray_data", out_data, 0);
    chk("stray_ready", 32'(in_ready), 1);
    chk("stray_req", 32'(mem_req_valid), 0);
    tick();

    // misaligned word load
    mem_rdata = 32'h0080FF00;
    issue(1'b1, 1'b0, 2'd0, READ_WORD, 32'h102, 32'h0, 32'h0);
`ifdef YSYX_23060184_LSU_MISALIGN_CHECK_EN
    chk("mis_no_req", 32'(mem_req_valid), 0);
    chk("mis_out_valid", 32'(out_valid), 1);
    chk("mis_fault", 32'(out_fault), 1);
    chk("mis_data", out_data, 0);
    tick();
    issue(1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h99);
    chk("mis_clr_fault", 32'(out_fault), 0);
    chk("mis_clr_data", out_data, 32'h99);
    tick();
`else
    chk("mis_req", 32'(mem_req_valid), 1);
    chk("mis_fault", 32'(out_fault), 0);
    finish_mem();
    chk("mis_data", out_data, 32'h0080FF00);
    chk("mis_fault_done", 32'(out_fault), 0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
